// File: rtl/gpioemu_pkg.sv
// gpioemu_pkg: register map, control/status bit positions and FSM states for the MAC peripheral.
package gpioemu_pkg;
  localparam logic [15:0] OFF_A1 = 16'h0000;
  localparam logic [15:0] OFF_A2 = 16'h0008;
  localparam logic [15:0] OFF_W  = 16'h0010;
  localparam logic [15:0] OFF_L  = 16'h0018;
  localparam logic [15:0] OFF_CS = 16'h0020;
  localparam logic [15:0] OFF_WH = 16'h0028;
  localparam int CTRL_START   = 0;
  localparam int CTRL_ACC     = 1;
  localparam int CTRL_CLR_ERR = 2;
  localparam int STAT_VALID   = 0;
  localparam int STAT_READY   = 1;
  localparam int STAT_ERR     = 2;
  typedef enum logic [1:0] {IDLE, MULT, POPC, DONE} state_t;
endpackage

// File: rtl/gpioemu_mac_if.sv
// gpioemu_mac_if: level-strobed register bus between host and the MAC peripheral.
interface gpioemu_mac_if;
  logic [15:0] saddress;
  logic        srd;
  logic        swr;
  logic [31:0] sdata_in;
  logic [31:0] sdata_out;
  modport master (output saddress, srd, swr, sdata_in, input sdata_out);
  modport slave  (input saddress, srd, swr, sdata_in, output sdata_out);
endinterface

// File: rtl/gpioemu_popcount.sv
// gpioemu_popcount: combinational population count built as a recursive binary adder tree.
module gpioemu_popcount #(
  parameter int W = 32
) (
  input  logic [W-1:0]             in,
  output logic [$clog2(W+1)-1:0]   count
);
  localparam int CW = $clog2(W+1);
  if (W == 1) begin : g_leaf
    assign count = in;
  end else begin : g_node
    localparam int WL = W / 2;
    localparam int WR = W - WL;
    logic [$clog2(WL+1)-1:0] cl;
    logic [$clog2(WR+1)-1:0] cr;
    gpioemu_popcount #(.W(WL)) u_lo (.in(in[WL-1:0]), .count(cl));
    gpioemu_popcount #(.W(WR)) u_hi (.in(in[W-1:WL]), .count(cr));
    assign count = CW'(cl) + CW'(cr);
  end
endmodule

// File: rtl/gpioemu_mac.sv
// gpioemu_mac: bus-mapped iterative shift-add multiplier with accumulate, overflow flag, popcount and op counter.
module gpioemu_mac
  import gpioemu_pkg::*;
#(
  parameter int          OP_W      = 24,
  parameter int          RES_W     = 32,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] BASE_ADDR = 16'h0380
) (
  input  logic                clk,
  input  logic                reset,
  gpioemu_mac_if.slave        bus,
  input  logic [31:0]         gpio_in,
  input  logic                gpio_latch,
  output logic [31:0]         gpio_out,
  output logic [31:0]         gpio_in_s_insp
);
  localparam int PW  = 2 * OP_W;
  localparam int HW  = (PW > RES_W) ? PW - RES_W : 1;
  localparam int LW  = $clog2(RES_W + 1);
  localparam int IW  = $clog2(OP_W);
  state_t            state_q, state_d;
  logic              srd_q, swr_q, rd_ev, wr_ev;
  logic              sel_a1, sel_a2, sel_w, sel_l, sel_cs, sel_wh;
  logic              go, err_set, clr_err, last;
  logic [OP_W-1:0]   a1, a2, mplier;
  logic [PW-1:0]     mcand, prod, addend, hi;
  logic [PW:0]       sum;
  logic [IW-1:0]     idx;
  logic [RES_W-1:0]  w, w_nx;
  logic [HW-1:0]     wh;
  logic [LW-1:0]     l, pc;
  logic              valid, ready, err;
  logic [CNT_W-1:0]  op_count;
  logic [31:0]       gpio_in_s, rdata;
  assign rd_ev   = bus.srd & ~srd_q;
  assign wr_ev   = bus.swr & ~swr_q;
  assign sel_a1  = bus.saddress == BASE_ADDR + OFF_A1;
  assign sel_a2  = bus.saddress == BASE_ADDR + OFF_A2;
  assign sel_w   = bus.saddress == BASE_ADDR + OFF_W;
  assign sel_l   = bus.saddress == BASE_ADDR + OFF_L;
  assign sel_cs  = bus.saddress == BASE_ADDR + OFF_CS;
  assign sel_wh  = bus.saddress == BASE_ADDR + OFF_WH;
  assign go      = wr_ev & sel_cs & bus.sdata_in[CTRL_START] & ready;
  assign err_set = wr_ev & ~ready & ((sel_cs & bus.sdata_in[CTRL_START]) | sel_a1 | sel_a2);
  assign clr_err = wr_ev & sel_cs & bus.sdata_in[CTRL_CLR_ERR];
  assign last    = idx == IW'(OP_W - 1);
  assign addend  = mplier[idx] ? mcand << idx : '0;
  assign sum     = {1'b0, prod} + {1'b0, addend};
  assign w_nx    = RES_W'(prod);
  assign hi      = prod >> RES_W;
  assign rdata   = sel_w  ? 32'(w) :
                   sel_l  ? 32'(l) :
                   sel_wh ? 32'(wh) :
                   sel_cs ? {29'b0, err, ready, valid} : '0;
  assign gpio_out       = 32'(op_count);
  assign gpio_in_s_insp = gpio_in_s;
  gpioemu_popcount #(.W(RES_W)) u_popc (.in(w_nx), .count(pc));
  always_ff @(posedge clk) state_q <= reset ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = go ? MULT : IDLE;
      MULT:    state_d = last ? POPC : MULT;
      POPC:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // Strobe history loads the live level during reset so a strobe held across reset raises no event.
  always_ff @(posedge clk) begin
    srd_q <= bus.srd;
    swr_q <= bus.swr;
    if (reset) begin
      bus.sdata_out <= '0;
      gpio_in_s     <= '0;
      op_count      <= '0;
      a1            <= '0;
      a2            <= '0;
      mplier        <= '0;
      mcand         <= '0;
      prod          <= '0;
      idx           <= '0;
      w             <= '0;
      wh            <= '0;
      l             <= '0;
      valid         <= 1'b1;
      ready         <= 1'b1;
      err           <= 1'b0;
    end else begin
      if (gpio_latch) gpio_in_s <= gpio_in;
      if (rd_ev) bus.sdata_out <= rdata;
      if (wr_ev && sel_a1 && ready) a1 <= bus.sdata_in[OP_W-1:0];
      if (wr_ev && sel_a2 && ready) a2 <= bus.sdata_in[OP_W-1:0];
      err <= err_set | (err & ~clr_err);
      case (state_q)
        IDLE: if (go) begin
          ready  <= 1'b0;
          valid  <= 1'b1;
          prod   <= bus.sdata_in[CTRL_ACC] ? (PW'(wh) << RES_W) | PW'(w) : '0;
          mcand  <= PW'(a1);
          mplier <= a2;
          idx    <= '0;
        end
        MULT: begin
          prod <= sum[PW-1:0];
          if (sum[PW]) valid <= 1'b0;
          idx  <= idx + 1'b1;
        end
        POPC: begin
          w  <= w_nx;
          wh <= HW'(hi);
          l  <= pc;
          if (hi != '0) valid <= 1'b0;
        end
        default: begin
          ready    <= 1'b1;
          op_count <= op_count + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gpioemu_mac.sv
// tb_gpioemu_mac: directed bus-level scenarios for the MAC peripheral with hand-computed expectations.
module tb_gpioemu_mac;
  localparam int          OP_W = 24;
  localparam logic [15:0] B    = 16'h0380;
  localparam logic [15:0] R_A1 = B + 16'h00;
  localparam logic [15:0] R_A2 = B + 16'h08;
  localparam logic [15:0] R_W  = B + 16'h10;
  localparam logic [15:0] R_L  = B + 16'h18;
  localparam logic [15:0] R_CS = B + 16'h20;
  localparam logic [15:0] R_WH = B + 16'h28;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] gpio_in = '0;
  logic gpio_latch = 1'b0;
  logic [31:0] gpio_out, gpio_in_s_insp;
  int asserts = 0;
  int fails = 0;
  always #5 clk = ~clk;
  gpioemu_mac_if bus ();
  gpioemu_mac dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .gpio_in(gpio_in),
    .gpio_latch(gpio_latch), .gpio_out(gpio_out), .gpio_in_s_insp(gpio_in_s_insp)
  );
  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    bus.saddress = a;
    bus.sdata_in = d;
    bus.swr = 1'b1;
    @(posedge clk); #1;
    bus.swr = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    bus.saddress = a;
    bus.srd = 1'b1;
    @(posedge clk); #1;
    bus.srd = 1'b0;
    d = bus.sdata_out;
    @(posedge clk); #1;
  endtask
  task automatic wait_ready();
    logic [31:0] d;
    d = '0;
    for (int k = 0; k < 40; k++) begin
      rd(R_CS, d);
      if (d[1]) break;
    end
    asserts++;
    if (d[1] !== 1'b1) begin fails++; $display("FAIL wait_ready: stat %h, ready never returned", d); end
  endtask
  task automatic test_reset();
    logic [31:0] d;
    bus.saddress = '0; bus.sdata_in = '0; bus.srd = 1'b0; bus.swr = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    rd(R_CS, d);
    asserts++; if (d !== 32'h3) begin fails++; $display("FAIL reset_stat: got %h want %h", d, 32'h3); end
    rd(R_W, d);
    asserts++; if (d !== 32'h0) begin fails++; $display("FAIL reset_w: got %h want 0", d); end
    rd(R_L, d);
    asserts++; if (d !== 32'h0) begin fails++; $display("FAIL reset_l: got %h want 0", d); end
    rd(R_WH, d);
    asserts++; if (d !== 32'h0) begin fails++; $display("FAIL reset_wh: got %h want 0", d); end
    asserts++; if (gpio_out !== 32'h0) begin fails++; $display("FAIL reset_gpio_out: got %h want 0", gpio_out); end
    asserts++; if (gpio_in_s_insp !== 32'h0) begin fails++; $display("FAIL reset_insp: got %h want 0", gpio_in_s_insp); end
  endtask
  task automatic test_mult();
    logic [31:0] d;
    wr(R_A1, 32'd3);
    wr(R_A2, 32'd5);
    wr(R_CS, 32'h1);
    repeat (OP_W) @(posedge clk); #1;
    asserts++; if (gpio_out !== 32'd0) begin fails++; $display("FAIL mult_early_count: got %h want 0", gpio_out); end
    @(posedge clk); #1;
    asserts++; if (gpio_out !== 32'd1) begin fails++; $display("FAIL mult_latency_count: got %h want 1", gpio_out); end
    rd(R_W, d);
    asserts++; if (d !== 32'd15) begin fails++; $display("FAIL mult_w: got %h want %h", d, 32'd15); end
    rd(R_L, d);
    asserts++; if (d !== 32'd4) begin fails++; $display("FAIL mult_l: got %h want 4", d); end
    rd(R_CS, d);
    asserts++; if (d !== 32'h3) begin fails++; $display("FAIL mult_stat: got %h want 3", d); end
  endtask
  task automatic test_overflow();
    logic [31:0] d;
    wr(R_A1, 32'hFFFFFF);
    wr(R_A2, 32'hFFFFFF);
    wr(R_CS, 32'h1);
    wait_ready();
    rd(R_W, d);
    asserts++; if (d !== 32'hFE000001) begin fails++; $display("FAIL ovf_w: got %h want fe000001", d); end
    rd(R_WH, d);
    asserts++; if (d !== 32'h0000FFFF) begin fails++; $display("FAIL ovf_wh: got %h want 0000ffff", d); end
    rd(R_L, d);
    asserts++; if (d !== 32'd8) begin fails++; $display("FAIL ovf_l: got %h want 8", d); end
    rd(R_CS, d);
    asserts++; if (d !== 32'h2) begin fails++; $display("FAIL ovf_stat: got %h want 2", d); end
    asserts++; if (gpio_out !== 32'd2) begin fails++; $display("FAIL ovf_count: got %h want 2", gpio_out); end
  endtask
  task automatic test_acc();
    logic [31:0] d;
    wr(R_A1, 32'd2);
    wr(R_A2, 32'd3);
    wr(R_CS, 32'h1);
    wait_ready();
    rd(R_W, d);
    asserts++; if (d !== 32'd6) begin fails++; $display("FAIL acc_base_w: got %h want 6", d); end
    rd(R_WH, d);
    asserts++; if (d !== 32'd0) begin fails++; $display("FAIL acc_base_wh: got %h want 0", d); end
    wr(R_A1, 32'd4);
    wr(R_A2, 32'd5);
    wr(R_CS, 32'h3);
    wait_ready();
    rd(R_W, d);
    asserts++; if (d !== 32'd26) begin fails++; $display("FAIL acc_w: got %h want %h", d, 32'd26); end
    rd(R_L, d);
    asserts++; if (d !== 32'd3) begin fails++; $display("FAIL acc_l: got %h want 3", d); end
    rd(R_CS, d);
    asserts++; if (d !== 32'h3) begin fails++; $display("FAIL acc_stat: got %h want 3", d); end
  endtask
  task automatic test_busy_err();
    logic [31:0] d;
    wr(R_A1, 32'd6);
    wr(R_A2, 32'd7);
    wr(R_CS, 32'h1);
    @(posedge clk); #1;
    wr(R_CS, 32'h1);
    wr(R_A1, 32'd9);
    rd(R_CS, d);
    asserts++; if (d !== 32'h5) begin fails++; $display("FAIL busy_stat: got %h want 5", d); end
    wait_ready();
    rd(R_CS, d);
    asserts++; if (d !== 32'h7) begin fails++; $display("FAIL busy_done_stat: got %h want 7", d); end
    rd(R_W, d);
    asserts++; if (d !== 32'd42) begin fails++; $display("FAIL busy_w: got %h want %h", d, 32'd42); end
    wr(R_CS, 32'h1);
    wait_ready();
    rd(R_W, d);
    asserts++; if (d !== 32'd42) begin fails++; $display("FAIL busy_a1_kept: got %h want %h", d, 32'd42); end
    wr(R_CS, 32'h4);
    rd(R_CS, d);
    asserts++; if (d !== 32'h3) begin fails++; $display("FAIL clr_err_stat: got %h want 3", d); end
    asserts++; if (gpio_out !== 32'd6) begin fails++; $display("FAIL busy_count: got %h want 6", gpio_out); end
  endtask
  task automatic test_reset_abort();
    logic [31:0] d;
    wr(R_A1, 32'd3);
    wr(R_A2, 32'd5);
    wr(R_CS, 32'h1);
    repeat (8) @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rd(R_CS, d);
    asserts++; if (d !== 32'h3) begin fails++; $display("FAIL abort_stat: got %h want 3", d); end
    rd(R_W, d);
    asserts++; if (d !== 32'h0) begin fails++; $display("FAIL abort_w: got %h want 0", d); end
    asserts++; if (gpio_out !== 32'h0) begin fails++; $display("FAIL abort_count: got %h want 0", gpio_out); end
    bus.saddress = R_CS;
    bus.sdata_in = 32'h1;
    bus.swr = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk); #1;
    bus.swr = 1'b0;
    @(posedge clk); #1;
    rd(R_CS, d);
    asserts++; if (d !== 32'h3) begin fails++; $display("FAIL held_strobe_stat: got %h want 3", d); end
    gpio_in = 32'h0000A5A5;
    gpio_latch = 1'b1;
    @(posedge clk); #1;
    gpio_latch = 1'b0;
    gpio_in = 32'h00001234;
    @(posedge clk); #1;
    asserts++; if (gpio_in_s_insp !== 32'h0000A5A5) begin fails++; $display("FAIL latch_insp: got %h want 0000a5a5", gpio_in_s_insp); end
  endtask
  initial begin
    test_reset();
    test_mult();
    test_overflow();
    test_acc();
    test_busy_err();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
